rot_step_decoder: RTL and testbench



---
 rtl/rot_pkg.sv | 41 ++++
 rtl/rot_debounce.sv | 51 +++++
 rtl/rot_step_decoder.sv | 137 +++++++++++++
 tb/tb_rot_step_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared constants and state encodings for the rotary step decoder
package rot_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CW1    = 3'd1;
  localparam logic [2:0] ST_CW2    = 3'd2;
  localparam logic [2:0] ST_CW3    = 3'd3;
  localparam logic [2:0] ST_CCW1   = 3'd4;
  localparam logic [2:0] ST_CCW2   = 3'd5;
  localparam logic [2:0] ST_CCW3   = 3'd6;
  localparam logic [2:0] ST_RESYNC = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CW1    = ST_CW1,
    CW2    = ST_CW2,
    CW3    = ST_CW3,
    CCW1   = ST_CCW1,
    CCW2   = ST_CCW2,
    CCW3   = ST_CCW3,
    RESYNC = ST_RESYNC
  } rot_state_e;

  // Both encoder pins high: the detent rest position.
  localparam logic [1:0] AB_IDLE = 2'b11;

  localparam logic [19:0] DEB_CYCLES_DEF = 20'd500000;

  // AB level each tracking state was entered on; RESYNC has no fixed level.
  function automatic logic [1:0] state_ab(input rot_state_e st);
    logic [1:0] ab;
    case (st)
      CW1, CCW3: ab = 2'b01;
      CW2, CCW2: ab = 2'b00;
      CW3, CCW1: ab = 2'b10;
      default:   ab = AB_IDLE;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/rot_debounce.sv
// rtl/rot_debounce.sv - two-flop synchroniser followed by a stability-count debouncer
module rot_debounce
  import rot_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        deb_q, deb_d;
  logic [19:0] cnt_q, cnt_d;

  // Synchronise, then flip the debounced level only after DEB_CYCLES mismatched clocks in a row.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_CYCLES - 20'd1) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // Synchroniser, debounced level and stability counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      deb_q   <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/rot_step_decoder.sv
// rtl/rot_step_decoder.sv - rotary encoder conditioning, quadrature step decode and position count
module rot_step_decoder
  import rot_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int          CNT_W      = 6,
  parameter bit          WRAP       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ROT,
  output logic [CNT_W-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       a_deb, b_deb, push_deb;
  logic [1:0] ab;

  rot_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_a (
    .clk(clk), .rst(rst), .din(ROT[0]), .dout(a_deb)
  );
  rot_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_b (
    .clk(clk), .rst(rst), .din(ROT[1]), .dout(b_deb)
  );
  rot_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_push (
    .clk(clk), .rst(rst), .din(ROT[2]), .dout(push_deb)
  );

  assign ab = {a_deb, b_deb};

  rot_state_e       state_q, state_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_prev_q, push_prev_d;
  logic [1:0]       exp_ab;

  // Quadrature walk: single-bit moves advance or back off, two-bit jumps go to RESYNC.
  always_comb begin
    state_d   = state_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    err_d     = 1'b0;
    exp_ab    = state_ab(state_q);
    if (state_q == RESYNC) begin
      if (ab == AB_IDLE) state_d = IDLE;
    end else if (ab != exp_ab) begin
      if ((ab ^ exp_ab) == 2'b11) begin
        err_d   = 1'b1;
        state_d = RESYNC;
      end else begin
        case (state_q)
          IDLE:    state_d = (ab == 2'b01) ? CW1 : CCW1;
          CW1:     state_d = (ab == 2'b00) ? CW2 : IDLE;
          CW2:     state_d = (ab == 2'b10) ? CW3 : CW1;
          CW3: begin
            if (ab == AB_IDLE) begin
              state_d   = IDLE;
              step_up_d = 1'b1;
            end else begin
              state_d = CW2;
            end
          end
          CCW1:    state_d = (ab == 2'b00) ? CCW2 : IDLE;
          CCW2:    state_d = (ab == 2'b01) ? CCW3 : CCW1;
          CCW3: begin
            if (ab == AB_IDLE) begin
              state_d   = IDLE;
              step_dn_d = 1'b1;
            end else begin
              state_d = CCW2;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Position count: a fresh push press clears, otherwise apply the step with wrap or clamp.
  always_comb begin
    push_prev_d = push_deb;
    dir_d       = dir_q;
    count_d     = count_q;
    if (step_up_d) begin
      dir_d = 1'b1;
      if (WRAP || (count_q != CNT_MAX)) count_d = count_q + CNT_ONE;
    end else if (step_dn_d) begin
      dir_d = 1'b0;
      if (WRAP || (count_q != '0)) count_d = count_q - CNT_ONE;
    end
    if (push_deb && !push_prev_q) count_d = '0;
  end

  // FSM state with its registered step, error and direction outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      err_q     <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      err_q     <= err_d;
      dir_q     <= dir_d;
    end
  end

  // Count register and push edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      push_prev_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      push_prev_q <= push_prev_d;
    end
  end

  assign count   = count_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign dir     = dir_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rot_step_decoder.sv
// tb/tb_rot_step_decoder.sv - scoreboard bench for rot_step_decoder (wrapping and saturating)
module tb_rot_step_decoder;
  import rot_pkg::*;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [2:0] K_UP  = 3'b001;
  localparam logic [2:0] K_DN  = 3'b010;
  localparam logic [2:0] K_ERR = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rot;

  logic [5:0] count_w, count_s;
  logic       su_w, sd_w, dir_w, err_w;
  logic       su_s, sd_s, dir_s, err_s;

  always #5 clk = ~clk;

  rot_step_decoder #(.DEB_CYCLES(DEB), .CNT_W(6), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst_n), .ROT(rot), .count(count_w),
    .step_up(su_w), .step_dn(sd_w), .dir(dir_w), .err(err_w)
  );

  rot_step_decoder #(.DEB_CYCLES(DEB), .CNT_W(6), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst_n), .ROT(rot), .count(count_s),
    .step_up(su_s), .step_dn(sd_s), .dir(dir_s), .err(err_s)
  );

  typedef struct {
    logic [2:0] kind;
    logic [5:0] cw;
    logic [5:0] cs;
    logic       dir;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   a_chg   = 0;
  logic a_prev  = 1'b1;

  logic [5:0] m_cw = 6'd0;
  logic [5:0] m_cs = 6'd0;
  logic       m_dir = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.a_deb !== a_prev) a_chg <= a_chg + 1;
    a_prev <= dut.a_deb;
  end

  // Pop one expectation per observed pulse and compare both instances against it.
  always @(negedge clk) begin
    if (rst_n && (su_w || sd_w || err_w || su_s || sd_s || err_s)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {26'd0, err_s, sd_s, su_s, err_w, sd_w, su_w}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("kind_wrap", {29'd0, err_w, sd_w, su_w}, {29'd0, e.kind});
        check("kind_sat", {29'd0, err_s, sd_s, su_s}, {29'd0, e.kind});
        check("count_wrap", {26'd0, count_w}, {26'd0, e.cw});
        check("count_sat", {26'd0, count_s}, {26'd0, e.cs});
        check("dir", {31'd0, dir_w}, {31'd0, e.dir});
        if (e.t >= 0) check("latency_cycle", cyc, e.t);
      end
    end
  end

  task automatic expect_ev(input logic [2:0] kind, input bit clr, input bit timed);
    exp_t x;
    if (kind == K_UP) begin
      m_cw  = m_cw + 6'd1;
      m_cs  = (m_cs == 6'd63) ? m_cs : m_cs + 6'd1;
      m_dir = 1'b1;
    end else if (kind == K_DN) begin
      m_cw  = m_cw - 6'd1;
      m_cs  = (m_cs == 6'd0) ? m_cs : m_cs - 6'd1;
      m_dir = 1'b0;
    end
    if (clr) begin
      m_cw = 6'd0;
      m_cs = 6'd0;
    end
    x.kind = kind;
    x.cw   = m_cw;
    x.cs   = m_cs;
    x.dir  = m_dir;
    x.t    = timed ? cyc + 7 : -1;
    sb.push_back(x);
  endtask

  // Called just after a rising edge; drives AB and holds it for n clocks.
  task automatic step_ab(input logic [1:0] ab, input int n);
    rot[0] = ab[1];
    rot[1] = ab[0];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cw_detent(input bit push_last, input bit timed);
    step_ab(2'b01, 10);
    step_ab(2'b00, 10);
    step_ab(2'b10, 10);
    expect_ev(K_UP, push_last, timed);
    if (push_last) rot[2] = 1'b1;
    step_ab(2'b11, 10);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    rot   = 3'b011;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cw  = 6'd0;
    m_cs  = 6'd0;
    m_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    rst_n = 1'b0;
    rot   = 3'b011;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count_wrap", {26'd0, count_w}, 32'd0);
    check("rst_count_sat", {26'd0, count_s}, 32'd0);
    check("rst_pulses", {29'd0, su_w, sd_w, err_w}, 32'd0);
    check("rst_dir", {31'd0, dir_w}, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    step_ab(2'b11, 5);

    // clean clockwise detent with latency check
    cw_detent(1'b0, 1'b1);
    check("cw_sb_empty", sb.size(), 32'd0);

    // counter-clockwise from zero: wraps to 63 vs clamps at 0
    reset_dut();
    step_ab(2'b10, 10);
    step_ab(2'b00, 10);
    step_ab(2'b01, 10);
    expect_ev(K_DN, 1'b0, 1'b1);
    step_ab(2'b11, 10);
    check("ccw_sb_empty", sb.size(), 32'd0);

    // bouncing A on the first transition
    a0 = a_chg;
    step_ab(2'b01, 2);
    step_ab(2'b11, 1);
    step_ab(2'b01, 3);
    step_ab(2'b11, 2);
    step_ab(2'b01, 10);
    check("bounce_a_changes", a_chg - a0, 32'd1);
    step_ab(2'b00, 10);
    step_ab(2'b10, 10);
    expect_ev(K_UP, 1'b0, 1'b0);
    step_ab(2'b11, 10);
    check("bounce_sb_empty", sb.size(), 32'd0);

    // dither back to idle, then complete the detent
    step_ab(2'b01, 10);
    step_ab(2'b11, 10);
    step_ab(2'b01, 10);
    step_ab(2'b00, 10);
    step_ab(2'b10, 10);
    expect_ev(K_UP, 1'b0, 1'b0);
    step_ab(2'b11, 10);
    step_ab(2'b01, 10);
    step_ab(2'b11, 15);
    check("dither_sb_empty", sb.size(), 32'd0);

    // illegal two-bit jump, resync path, then a clean detent
    expect_ev(K_ERR, 1'b0, 1'b1);
    step_ab(2'b00, 10);
    check("resync_state", 32'(dut.state_q), 32'(ST_RESYNC));
    step_ab(2'b10, 10);
    step_ab(2'b11, 10);
    check("resync_sb_empty", sb.size(), 32'd0);
    check("resync_idle", 32'(dut.state_q), 32'(ST_IDLE));
    cw_detent(1'b0, 1'b0);

    // push lands on the same edge as a step; holding push does not re-clear
    reset_dut();
    for (int i = 0; i < 5; i++) cw_detent(1'b0, 1'b0);
    check("pre_push_count", {26'd0, count_w}, 32'd5);
    cw_detent(1'b1, 1'b1);
    cw_detent(1'b0, 1'b0);
    rot[2] = 1'b0;
    step_ab(2'b11, 10);
    check("push_sb_empty", sb.size(), 32'd0);
    check("push_hold_count", {26'd0, count_w}, 32'd1);

    // reset in the middle of a detent discards it
    step_ab(2'b01, 10);
    step_ab(2'b00, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_count", {26'd0, count_w}, 32'd0);
    check("midrst_outs", {28'd0, su_w, sd_w, err_w, dir_w}, 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rot = 3'b011;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cw  = 6'd0;
    m_cs  = 6'd0;
    m_dir = 1'b0;
    step_ab(2'b10, 10);
    step_ab(2'b11, 15);
    check("midrst_sb_empty", sb.size(), 32'd0);
    check("midrst_final_count", {26'd0, count_w}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
